fifo_cam: RTL and testbench

FIFO_CAM -- requirements
Module: fifo_cam

---
 rtl/fifo_cam_if.sv | 20 ++
 rtl/fifo_cam.sv | 134 +++++++++++++
 tb/tb_fifo_cam.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_cam_if.sv
// Handshake bundle between the camera-side FIFO and its producer/consumer.
// The almost_full signal exists only when FIFO_CAM_ALMOST_FULL_EN is defined.
`timescale 1ns/1ps
interface fifo_cam_if #(parameter int WIDTH = 17);
  logic             wr_en;
  logic [WIDTH-1:0] data;
  logic             full;
  logic             rd_en;
  logic [WIDTH-1:0] q;
  logic             empty;
`ifdef FIFO_CAM_ALMOST_FULL_EN
  logic             almost_full;

  modport master (output wr_en, data, rd_en, input full, q, empty, almost_full);
  modport slave  (input wr_en, data, rd_en, output full, q, empty, almost_full);
`else
  modport master (output wr_en, data, rd_en, input full, q, empty);
  modport slave  (input wr_en, data, rd_en, output full, q, empty);
`endif
endinterface

// File: rtl/fifo_cam.sv
// fifo_cam: dual-clock FIFO carrying camera pixels (bit 16 = marker, 15:0 = pixel).
// Write side on clk, read side on rd_clk; pointers cross as Gray code through
// 2-flop synchronizers. Optional almost_full output enabled by the macro
// FIFO_CAM_ALMOST_FULL_EN (default build: absent).
`timescale 1ns/1ps
module fifo_cam #(
  parameter int WIDTH    = 17,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = 1000
) (
  input logic      clk,
  input logic      reset_n,
  input logic      rd_clk,
  fifo_cam_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 16) || (AF_LEVEL > DEPTH)) begin : g_bad_param
    $error("fifo_cam: DEPTH must be a power of two >= 16 and AF_LEVEL <= DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  // write domain
  logic [1:0]  wr_rst_sync;
  logic        wr_ok;
  logic [AW:0] wr_bin, wr_bin_nxt, wr_gray, wr_gray_nxt;
  logic [AW:0] rd_gray_w1, rd_gray_w2;
  logic        wr_inc, full_r, full_nxt;

  // read domain
  logic [1:0]  rd_rst_sync;
  logic        rd_ok;
  logic [AW:0] rd_bin, rd_bin_nxt, rd_gray, rd_gray_nxt;
  logic [AW:0] wr_gray_r1, wr_gray_r2;
  logic        rd_inc, empty_r, empty_nxt;

  // Reset assertion is immediate; release is seen only after two clk edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_rst_sync <= 2'b00;
    else          wr_rst_sync <= {wr_rst_sync[0], 1'b1};
  end
  assign wr_ok = wr_rst_sync[1];

  // Same release synchronization for the read domain.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) rd_rst_sync <= 2'b00;
    else          rd_rst_sync <= {rd_rst_sync[0], 1'b1};
  end
  assign rd_ok = rd_rst_sync[1];

  // Write pointer advance and full look-ahead against the synchronized read pointer.
  always_comb begin
    wr_inc      = bus.wr_en & ~full_r & wr_ok;
    wr_bin_nxt  = wr_bin + (AW+1)'(wr_inc);
    wr_gray_nxt = (wr_bin_nxt >> 1) ^ wr_bin_nxt;
    full_nxt    = (wr_gray_nxt == {~rd_gray_w2[AW:AW-1], rd_gray_w2[AW-2:0]});
  end

  // Write-domain pointer, full flag and read-pointer synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bin     <= '0;
      wr_gray    <= '0;
      full_r     <= 1'b0;
      rd_gray_w1 <= '0;
      rd_gray_w2 <= '0;
    end else begin
      wr_bin     <= wr_bin_nxt;
      wr_gray    <= wr_gray_nxt;
      full_r     <= full_nxt;
      rd_gray_w1 <= rd_gray;
      rd_gray_w2 <= rd_gray_w1;
    end
  end

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_inc) mem[wr_bin[AW-1:0]] <= bus.data;
  end

  // Read pointer advance and empty look-ahead against the synchronized write pointer.
  always_comb begin
    rd_inc      = bus.rd_en & ~empty_r & rd_ok;
    rd_bin_nxt  = rd_bin + (AW+1)'(rd_inc);
    rd_gray_nxt = (rd_bin_nxt >> 1) ^ rd_bin_nxt;
    empty_nxt   = (rd_gray_nxt == wr_gray_r2);
  end

  // Read-domain pointer, output register, empty flag and write-pointer synchronizer.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bin     <= '0;
      rd_gray    <= '0;
      empty_r    <= 1'b1;
      bus.q      <= '0;
      wr_gray_r1 <= '0;
      wr_gray_r2 <= '0;
    end else begin
      rd_bin     <= rd_bin_nxt;
      rd_gray    <= rd_gray_nxt;
      empty_r    <= empty_nxt;
      wr_gray_r1 <= wr_gray;
      wr_gray_r2 <= wr_gray_r1;
      if (rd_inc) bus.q <= mem[rd_bin[AW-1:0]];
    end
  end

  assign bus.full  = full_r;
  assign bus.empty = empty_r;

`ifdef FIFO_CAM_ALMOST_FULL_EN
  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
  logic [AW:0] rd_bin_w, fill_nxt;
  logic        af_r;

  // Fill count seen from the write side; lags reads, so it never under-reports.
  always_comb begin
    rd_bin_w = '0;
    for (int i = AW; i >= 0; i--) begin
      if (i == AW) rd_bin_w[i] = rd_gray_w2[i];
      else         rd_bin_w[i] = rd_bin_w[i+1] ^ rd_gray_w2[i];
    end
    fill_nxt = wr_bin_nxt - rd_bin_w;
  end

  // Registered almost-full threshold compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) af_r <= 1'b0;
    else          af_r <= (fill_nxt >= AF_THR);
  end
  assign bus.almost_full = af_r;
`endif
endmodule

// File: tb/tb_fifo_cam.sv
// Self-checking bench for fifo_cam: table-driven fill/drain scenarios,
// directed corner sequences and a random dual-clock run, all against a
// scoreboard queue of written words.
`timescale 1ns/1ps
module tb_fifo_cam;
  localparam int WIDTH = 17;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rd_clk = 1'b0;
  logic reset_n = 1'b0;

  fifo_cam_if #(.WIDTH(WIDTH)) bus();

  fifo_cam #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(1000)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rd_clk (rd_clk),
    .bus    (bus)
  );

  always #18.519 clk = ~clk;     // ~27 MHz
  always #15.152 rd_clk = ~rd_clk; // ~33 MHz

  int n_assert = 0;
  int n_fail   = 0;
  int count    = 0;
  bit mon_en   = 1'b0;
  logic [16:0] exp_q[$];
  logic [16:0] last_q = '0;

  typedef struct {
    int          n_wr;
    logic [16:0] base;
    bit          exp_full;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr_word(input logic [16:0] d);
    int t = 0;
    while (bus.full && t < 200) begin @(posedge clk); #1; t++; end
    if (bus.full) begin
      n_assert++; n_fail++;
      $display("FAIL wr_timeout actual=full required=not_full at %0t", $time);
      return;
    end
    bus.data = d; bus.wr_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    exp_q.push_back(d);
    count++;
  endtask

  task automatic rd_check(input string name);
    int t = 0;
    logic [16:0] e;
    while (bus.empty && t < 200) begin @(posedge rd_clk); #1; t++; end
    if (bus.empty) begin
      n_assert++; n_fail++;
      $display("FAIL %s_timeout actual=empty required=not_empty at %0t", name, $time);
      return;
    end
    bus.rd_en = 1'b1;
    @(posedge rd_clk); #1;
    bus.rd_en = 1'b0;
    count--;
    if (exp_q.size() == 0) begin
      n_assert++; n_fail++;
      $display("FAIL %s_underflow actual=%h required=no_word", name, bus.q);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(bus.q), 32'(e));
    end
    last_q = bus.q;
  endtask

  // Flags must never be optimistic relative to the bench's own word count.
  always @(negedge clk) if (mon_en) begin
    n_assert++;
    if (!bus.full && count >= DEPTH) begin
      n_fail++;
      $display("FAIL full_flag actual=0 required=1 count=%0d at %0t", count, $time);
    end
  end
  always @(negedge rd_clk) if (mon_en) begin
    n_assert++;
    if (!bus.empty && count == 0) begin
      n_fail++;
      $display("FAIL empty_flag actual=0 required=1 count=0 at %0t", $time);
    end
  end

  initial begin
    vec_t vecs[5];
    int t;
    int n;
    vecs[0] = '{1,         17'h0_0055, 1'b0};
    vecs[1] = '{16,        17'h1_0000, 1'b0};
    vecs[2] = '{DEPTH-1,   17'h0_1234, 1'b0};
    vecs[3] = '{DEPTH,     17'h1_F000, 1'b1};
    vecs[4] = '{DEPTH+1,   17'h0_8000, 1'b1};

    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data = '0;
    #60;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_q",     32'(bus.q),     32'd0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    repeat (4) @(posedge rd_clk);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Table: burst of writes with no reads, exact full tracking, then drain.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n_wr; i++) begin
        bus.data = vecs[v].base + 17'(i);
        bus.wr_en = 1'b1;
        @(posedge clk); #1;
        if (count < DEPTH) begin
          exp_q.push_back(vecs[v].base + 17'(i));
          count++;
        end
        chk("tbl_full_edge", 32'(bus.full), 32'(count == DEPTH));
      end
      bus.wr_en = 1'b0;
      repeat (5) @(posedge clk); #1;
      chk("tbl_full", 32'(bus.full), 32'(vecs[v].exp_full));
      n = count;
      for (int i = 0; i < n; i++) rd_check("tbl_q");
      chk("tbl_empty_end", 32'(bus.empty), 32'd1);
      repeat (5) @(posedge clk); #1;
      chk("tbl_full_end", 32'(bus.full), 32'd0);
    end

    // Marker/data pattern, 483 words.
    wr_word(17'h1_0000);
    wr_word(17'h1_0001);
    for (int i = 0; i < 'h1E0; i++) wr_word(17'(i));
    wr_word(17'h1_FFFF);
    repeat (5) @(posedge rd_clk); #1;
    for (int i = 0; i < 483; i++) rd_check("seq483_q");
    chk("seq483_empty", 32'(bus.empty), 32'd1);

    // Fill, free one word, measure full release, refill by one.
    for (int i = 0; i < DEPTH; i++) wr_word(17'(i * 7 + 3));
    chk("fill_full", 32'(bus.full), 32'd1);
    rd_check("free1_q");
    t = 0;
    @(posedge clk); #1; t++;
    while (bus.full && t < 10) begin @(posedge clk); #1; t++; end
    chk("full_release_le3", 32'(t <= 3), 32'd1);
    wr_word(17'h1_2345);
    chk("refill_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < DEPTH; i++) rd_check("refill_q");

    // rd_en held while empty: no change to q, empty, or the read pointer.
    @(posedge rd_clk); #1;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge rd_clk); #1;
      chk("hold_q", 32'(bus.q), 32'(last_q));
      chk("hold_empty", 32'(bus.empty), 32'd1);
    end
    bus.rd_en = 1'b0;
    @(posedge clk); #1;
    wr_word(17'h1_5A5A);
    t = 0;
    @(posedge rd_clk); #1; t++;
    while (bus.empty && t < 10) begin @(posedge rd_clk); #1; t++; end
    chk("empty_release_le3", 32'(t <= 3), 32'd1);
    rd_check("after_hold_q");

    // Random dual-clock traffic, several pointer wraps.
    fork
      begin
        for (int i = 0; i < 5000; i++) begin
          @(posedge clk); #1;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          wr_word(17'($urandom));
        end
      end
      begin
        for (int i = 0; i < 5000; i++) begin
          @(posedge rd_clk); #1;
          repeat ($urandom_range(0, 3)) begin @(posedge rd_clk); #1; end
          rd_check("rand_q");
        end
      end
    join
    chk("rand_left", 32'(exp_q.size()), 32'd0);

    // Reset with 500 words stored.
    @(posedge clk); #1;
    for (int i = 0; i < 500; i++) wr_word(17'(i + 17'h0_0300));
    repeat (5) @(posedge rd_clk);
    #3;
    reset_n = 1'b0;
    count = 0;
    exp_q.delete();
    #1;
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_full",  32'(bus.full),  32'd0);
    chk("midrst_q",     32'(bus.q),     32'd0);
    #50;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    repeat (4) @(posedge rd_clk);
    @(posedge clk); #1;
    wr_word(17'h0_0ABC);
    rd_check("post_rst_q");
    repeat (5) @(posedge rd_clk); #1;
    chk("post_rst_empty", 32'(bus.empty), 32'd1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
